// File: rtl/tune_sequencer.sv
// rtl/tune_sequencer.sv - table-driven melody player driving a square-wave phase accumulator
module tune_sequencer #(
    parameter int N         = 32,
    parameter int DEPTH     = 16,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [2:0]               wr_note,
    input  logic [DUR_W-1:0]         wr_dur,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic                     q,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [2:0] NOTE_END = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state, state_n;
    logic [AW-1:0]     ptr, ptr_n;
    logic [N-1:0]      acc, acc_n;
    logic [PW-1:0]     presc, presc_n;
    logic [DUR_W-1:0]  dcnt, dcnt_n;
    logic [N-1:0]      word, word_n;
    logic [DUR_W-1:0]  dur_l, dur_n;
    logic              done_n;

    logic [2:0]        note_mem [DEPTH];
    logic [DUR_W-1:0]  dur_mem  [DEPTH];

    logic [2:0]        rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic              tick_end;
    logic              do_adv;
    logic              do_finish;

    // Fixed keyboard tuning words; rests and unused codes stay silent.
    function automatic logic [N-1:0] tune(input logic [2:0] note);
        case (note)
            3'd1:    tune = N'(22471);
            3'd2:    tune = N'(28312);
            3'd3:    tune = N'(33673);
            3'd4:    tune = N'(37796);
            default: tune = '0;
        endcase
    endfunction

    assign rd_note  = note_mem[ptr];
    assign rd_dur   = dur_mem[ptr];
    assign tick_end = (presc == PW'(TICK_DIV - 1));

    // Table storage: cleared to END on reset, writable at any time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                note_mem[i] <= NOTE_END;
                dur_mem[i]  <= '0;
            end
        end else if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            acc   <= '0;
            presc <= '0;
            dcnt  <= '0;
            word  <= '0;
            dur_l <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            acc   <= acc_n;
            presc <= presc_n;
            dcnt  <= dcnt_n;
            word  <= word_n;
            dur_l <= dur_n;
            done  <= done_n;
        end
    end

    // Next-state logic: step sequencing, tick timing and accumulator update.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        acc_n     = acc;
        presc_n   = presc;
        dcnt_n    = dcnt;
        word_n    = word;
        dur_n     = dur_l;
        done_n    = 1'b0;
        do_adv    = 1'b0;
        do_finish = 1'b0;

        case (state)
            IDLE: begin
                acc_n = '0;
                if (start) begin
                    state_n = LOAD;
                    ptr_n   = '0;
                end
            end
            LOAD: begin
                acc_n   = '0;
                presc_n = '0;
                dcnt_n  = '0;
                if (rd_note == NOTE_END) begin
                    if (loop_en && ptr != '0) ptr_n = '0;
                    else                      do_finish = 1'b1;
                end else if (rd_dur == '0) begin
                    // A skipped last entry counts as hitting END.
                    if (ptr == LAST) begin
                        if (loop_en) ptr_n = '0;
                        else         do_finish = 1'b1;
                    end else begin
                        ptr_n = ptr + 1'b1;
                    end
                end else begin
                    word_n  = tune(rd_note);
                    dur_n   = rd_dur;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                acc_n   = acc + word;
                presc_n = tick_end ? '0 : presc + 1'b1;
                if (tick_end) begin
                    if (dcnt == dur_l - 1'b1) begin
                        dcnt_n = '0;
                        acc_n  = '0;
                        if (GAP_TICKS > 0) state_n = GAP;
                        else               do_adv  = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
            end
            GAP: begin
                acc_n   = '0;
                presc_n = tick_end ? '0 : presc + 1'b1;
                if (tick_end) begin
                    if (dcnt == DUR_W'(GAP_TICKS - 1)) begin
                        dcnt_n = '0;
                        do_adv = 1'b1;
                    end else begin
                        dcnt_n = dcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Moving on from the last entry behaves like reaching END.
        if (do_adv) begin
            state_n = LOAD;
            if (ptr == LAST) begin
                if (loop_en) ptr_n = '0;
                else         do_finish = 1'b1;
            end else begin
                ptr_n = ptr + 1'b1;
            end
        end

        if (do_finish) begin
            state_n = IDLE;
            ptr_n   = '0;
            done_n  = 1'b1;
        end

        // Abort wins over everything, including a simultaneous start.
        if (stop) begin
            state_n = IDLE;
            ptr_n   = '0;
            acc_n   = '0;
            presc_n = '0;
            dcnt_n  = '0;
            done_n  = 1'b0;
        end
    end

    assign q    = (state == PLAY) && (word != '0) && acc[N-1];
    assign busy = (state != IDLE);
    assign step = ptr;
endmodule

// File: tb/tb_tune_sequencer.sv
// tb/tb_tune_sequencer.sv - scoreboard bench for tune_sequencer
module tb_tune_sequencer;
    localparam int C_W = 22471;
    localparam int E_W = 28312;
    localparam int G_W = 33673;
    localparam int A_W = 37796;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [2:0]  wr_note = '0;
    logic [15:0] wr_dur = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        q, busy, done;
    logic [2:0]  step;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       busy;
        logic       done;
        logic       q;
        logic [2:0] step;
    } exp_t;

    exp_t sb[$];

    tune_sequencer #(.N(16), .DEPTH(8), .DUR_W(16), .TICK_DIV(4), .GAP_TICKS(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_dur(wr_dur), .start(start), .stop(stop), .loop_en(loop_en),
        .q(q), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int note, input int dur);
        wr_en = 1'b1;
        wr_addr = 3'(addr);
        wr_note = 3'(note);
        wr_dur = 16'(dur);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input int n, input logic b, input logic d, input logic qv, input int s);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.busy = b; e.done = d; e.q = qv; e.step = 3'(s);
            sb.push_back(e);
        end
    endtask

    // PLAY cycles: acc(k) = k*word mod 2^16, q = acc MSB for a non-zero word.
    task automatic push_play(input int cycles, input int word, input int s);
        exp_t e;
        int a;
        for (int k = 0; k < cycles; k++) begin
            a = (k * word) % 65536;
            e.busy = 1'b1; e.done = 1'b0; e.step = 3'(s);
            e.q = (word != 0) ? a[15] : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic run_sb(input string name, input bit do_start, input int start_at, input bit stop_last);
        exp_t e;
        int idx;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b want %b", name, idx, busy, e.busy);
            end
            checks++;
            if (done !== e.done) begin
                errors++;
                $display("FAIL %s done cyc%0d: got %b want %b", name, idx, done, e.done);
            end
            checks++;
            if (q !== e.q) begin
                errors++;
                $display("FAIL %s q cyc%0d: got %b want %b", name, idx, q, e.q);
            end
            checks++;
            if (step !== e.step) begin
                errors++;
                $display("FAIL %s step cyc%0d: got %0d want %0d", name, idx, step, e.step);
            end
            if (idx == start_at) start = 1'b1;
            if (stop_last && sb.size() == 0) stop = 1'b1;
            tick();
            start = 1'b0;
            stop = 1'b0;
            idx++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({q, busy, done, step} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got q=%b busy=%b done=%b step=%0d want all 0", q, busy, done, step);
        end
        reset = 1'b0;
        tick();
        push(1, 1, 0, 0, 0);
        push(1, 0, 1, 0, 0);
        push(2, 0, 0, 0, 0);
        run_sb("empty_table", 1, -1, 0);
    endtask

    task automatic test_table_play();
        write_entry(0, 1, 2);
        write_entry(1, 2, 1);
        write_entry(2, 7, 0);
        push(1, 1, 0, 0, 0);
        push_play(8, C_W, 0);
        push(4, 1, 0, 0, 0);
        push(1, 1, 0, 0, 1);
        push_play(4, E_W, 1);
        push(4, 1, 0, 0, 1);
        push(1, 1, 0, 0, 2);
        push(1, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0);
        run_sb("table_play", 1, -1, 0);
    endtask

    task automatic test_tone();
        logic [3:0] want;
        want = 4'b0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q !== want[k]) begin
                errors++;
                $display("FAIL tone_q k=%0d: got %b want %b", k, q, want[k]);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_rest_skip();
        write_entry(0, 0, 1);
        write_entry(1, 3, 0);
        write_entry(2, 4, 1);
        write_entry(3, 7, 0);
        push(1, 1, 0, 0, 0);
        push_play(4, 0, 0);
        push(4, 1, 0, 0, 0);
        push(1, 1, 0, 0, 1);
        push(1, 1, 0, 0, 2);
        push_play(4, A_W, 2);
        push(4, 1, 0, 0, 2);
        push(1, 1, 0, 0, 3);
        push(1, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0);
        run_sb("rest_skip", 1, -1, 0);
    endtask

    task automatic test_loop_stop();
        write_entry(0, 1, 1);
        write_entry(1, 7, 0);
        loop_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(1, 1, 0, 0, 0);
            push_play(4, C_W, 0);
            push(4, 1, 0, 0, 0);
            push(1, 1, 0, 0, 1);
        end
        push(1, 1, 0, 0, 0);
        push_play(3, C_W, 0);
        run_sb("loop", 1, -1, 1);
        loop_en = 1'b0;
        push(3, 0, 0, 0, 0);
        run_sb("after_stop", 0, -1, 0);
    endtask

    task automatic test_back_to_back();
        push(1, 1, 0, 0, 0);
        push_play(4, C_W, 0);
        push(4, 1, 0, 0, 0);
        push(1, 1, 0, 0, 1);
        push(1, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0);
        run_sb("start_while_busy", 1, 2, 0);

        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        push(3, 0, 0, 0, 0);
        run_sb("start_and_stop", 0, -1, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({q, busy, done, step} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_play: got q=%b busy=%b done=%b step=%0d want all 0", q, busy, done, step);
        end
        push(1, 1, 0, 0, 0);
        push(1, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0);
        run_sb("cleared_table", 1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_table_play();
        test_tone();
        test_rest_skip();
        test_loop_stop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
